// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single RAM port. A CPU port (read/write) and a
// display-fetch port (read-only) share it, and the display has a bounded burst priority.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_MAX     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_wEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_dataOut,
  input  logic                     disp_req,
  input  logic [ADDRESS_WIDTH-1:0] disp_addr,
  output logic                     disp_gnt,
  output logic                     disp_rvalid,
  output logic [DATA_WIDTH-1:0]    disp_dataOut,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} owner_t;

  owner_t          owner_q, owner_d;
  logic [CW-1:0]   burst_cnt, burst_nxt;
  logic            burst_full;

  assign burst_full = (burst_cnt == CW'(BURST_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      burst_cnt <= '0;
    end else begin
      owner_q   <= owner_d;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    cpu_gnt    = 1'b0;
    disp_gnt   = 1'b0;
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;
    owner_d    = OWN_NONE;
    burst_nxt  = burst_cnt;
    if (!reset) begin
      // Display wins ties until it has used up its burst allowance.
      cpu_gnt  = cpu_req && (!disp_req || burst_full);
      disp_gnt = disp_req && !cpu_gnt;
    end
    if (cpu_gnt) begin
      mem_wEn    = cpu_wEn;
      mem_addr   = cpu_addr;
      mem_dataIn = cpu_dataIn;
      owner_d    = cpu_wEn ? OWN_NONE : OWN_CPU;
    end else if (disp_gnt) begin
      mem_addr   = disp_addr;
      owner_d    = OWN_DISP;
    end
    if (cpu_gnt || !cpu_req)
      burst_nxt = '0;
    else if (disp_gnt && !burst_full)
      burst_nxt = burst_cnt + CW'(1);
  end

  // Masking with reset kills the response to a read granted just before reset.
  assign cpu_rvalid   = (owner_q == OWN_CPU)  && !reset;
  assign disp_rvalid  = (owner_q == OWN_DISP) && !reset;
  assign cpu_dataOut  = mem_dataOut;
  assign disp_dataOut = mem_dataOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural RAM on the shared port, directed vectors,
// burst/reset sequences, and random traffic checked against a reference model plus a read scoreboard.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wEn, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dataIn, cpu_dataOut;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_dataOut;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn, mem_dataOut;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dataOut(cpu_dataOut),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_dataOut(disp_dataOut),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 10) ? 32'hA5A5 : 32'h1000_0000 + DW'(i);
  endfunction

  // Synchronous RAM attached to the shared port (one-cycle read latency).
  logic [DW-1:0] env_ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) env_ram[i] = init_val(i);
    mem_dataOut = '0;
    forever begin
      @(posedge clk);
      mem_dataOut <= env_ram[mem_addr];
      if (mem_wEn) env_ram[mem_addr] = mem_dataIn;
    end
  end

  typedef struct { logic is_cpu; logic [DW-1:0] data; } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] ref_ram [0:(1<<AW)-1];
  int            m_cnt;
  int            checks, errors;
  logic          last_cg, last_dg;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs were driven at the preceding negedge.
  task automatic cycle();
    rd_t e;
    logic ec, ed, egc, egd;
    logic [DW-1:0] edata;
    #1;
    ec = 0; ed = 0; edata = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!reset) begin ec = e.is_cpu; ed = !e.is_cpu; edata = e.data; end
    end
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(ec));
    chk("disp_rvalid", 64'(disp_rvalid), 64'(ed));
    if (ec) chk("cpu_dataOut", 64'(cpu_dataOut), 64'(edata));
    if (ed) chk("disp_dataOut", 64'(disp_dataOut), 64'(edata));
    egc = 0; egd = 0;
    if (!reset) begin
      egc = cpu_req && (!disp_req || m_cnt == BM);
      egd = disp_req && !egc;
    end
    chk("cpu_gnt", 64'(cpu_gnt), 64'(egc));
    chk("disp_gnt", 64'(disp_gnt), 64'(egd));
    chk("one_grant", 64'(cpu_gnt && disp_gnt), 64'(0));
    chk("mem_wEn", 64'(mem_wEn), 64'(egc && cpu_wEn));
    chk("mem_addr", 64'(mem_addr), egc ? 64'(cpu_addr) : egd ? 64'(disp_addr) : 64'(0));
    chk("mem_dataIn", 64'(mem_dataIn), egc ? 64'(cpu_dataIn) : 64'(0));
    if (egc && !cpu_wEn) sb.push_back('{1'b1, ref_ram[cpu_addr]});
    if (egd)             sb.push_back('{1'b0, ref_ram[disp_addr]});
    if (egc && cpu_wEn)  ref_ram[cpu_addr] = cpu_dataIn;
    if (reset || egc || !cpu_req) m_cnt = 0;
    else if (egd && m_cnt < BM)   m_cnt++;
    last_cg = cpu_gnt; last_dg = disp_gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic cr, logic cw, logic [AW-1:0] ca, logic [DW-1:0] cd,
                       logic dr, logic [AW-1:0] da);
    cpu_req = cr; cpu_wEn = cw; cpu_addr = ca; cpu_dataIn = cd;
    disp_req = dr; disp_addr = da;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, '0);
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic cr, cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
    logic dr;     logic [AW-1:0] da;
    logic e_cg, e_dg, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
  } vec_t;
  vec_t vt [6];

  initial begin
    checks = 0; errors = 0; m_cnt = 0;
    for (int i = 0; i < (1<<AW); i++) ref_ram[i] = init_val(i);
    vt[0] = '{0, 0, 12'd0,    32'h0,   0, 12'd0,  0, 0, 0, 12'd0,    32'h0};
    vt[1] = '{1, 1, 12'd1002, 32'h5,   0, 12'd0,  1, 0, 1, 12'd1002, 32'h5};
    vt[2] = '{0, 0, 12'd0,    32'h0,   1, 12'd10, 0, 1, 0, 12'd10,   32'h0};
    vt[3] = '{1, 0, 12'd7,    32'h99,  0, 12'd0,  1, 0, 0, 12'd7,    32'h99};
    vt[4] = '{1, 1, 12'd20,   32'h77,  1, 12'd30, 0, 1, 0, 12'd30,   32'h0};
    vt[5] = '{1, 0, 12'd1002, 32'h0,   0, 12'd0,  1, 0, 0, 12'd1002, 32'h0};

    reset = 1'b1;
    drive(0, 0, '0, '0, 0, '0);
    @(negedge clk);
    cycle();
    chk("reset_cpu_gnt", 64'(last_cg), 64'(0));
    chk("reset_disp_gnt", 64'(last_dg), 64'(0));
    reset = 1'b0;

    // Directed single-cycle vectors, each from a fresh reset; the following idle
    // cycle lets the scoreboard check the read response.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      drive(vt[v].cr, vt[v].cw, vt[v].ca, vt[v].cd, vt[v].dr, vt[v].da);
      #1;
      chk("vec_cpu_gnt", 64'(cpu_gnt), 64'(vt[v].e_cg));
      chk("vec_disp_gnt", 64'(disp_gnt), 64'(vt[v].e_dg));
      chk("vec_mem_wEn", 64'(mem_wEn), 64'(vt[v].e_we));
      chk("vec_mem_addr", 64'(mem_addr), 64'(vt[v].e_addr));
      chk("vec_mem_dataIn", 64'(mem_dataIn), 64'(vt[v].e_din));
      cycle();
      drive(0, 0, '0, '0, 0, '0);
      #1;
      if (v == 2) begin
        chk("vec_disp_A5A5", 64'(disp_dataOut), 64'h A5A5);
        chk("vec_disp_rv_cpu", 64'(cpu_rvalid), 64'(0));
      end
      if (v == 5) chk("vec_readback_1002", 64'(cpu_dataOut), 64'h5);
      cycle();
    end

    // Both requesting continuously: D,D,D,D,C repeating.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, AW'(100 + k), '0, 1, AW'(200 + k));
      cycle();
      chk("burst_pattern_cpu", 64'(last_cg), 64'((k % 5) == 4));
    end

    // CPU drops after two display grants, then waits a full fresh burst.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(k != 2, 0, AW'(300 + k), '0, 1, AW'(400 + k));
      cycle();
      chk("burst_restart_cpu", 64'(last_cg), 64'(k == 7));
      chk("burst_restart_disp", 64'(last_dg), 64'(k != 7));
    end

    // Display read, then reset the next cycle: no rvalid may appear.
    do_reset();
    drive(0, 0, '0, '0, 1, 12'd10);
    cycle();
    reset = 1'b1;
    drive(0, 0, '0, '0, 1, 12'd11);
    #1;
    chk("rst_disp_rvalid_n1", 64'(disp_rvalid), 64'(0));
    chk("rst_disp_gnt_n1", 64'(disp_gnt), 64'(0));
    cycle();
    reset = 1'b0;
    drive(0, 0, '0, '0, 0, '0);
    #1;
    chk("rst_disp_rvalid_n2", 64'(disp_rvalid), 64'(0));
    cycle();

    // Random traffic against the model.
    for (int k = 0; k < 10000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, AW'($urandom),
            $urandom, $urandom_range(0, 2) != 0, AW'($urandom));
      cycle();
    end
    reset = 1'b0;
    drive(0, 0, '0, '0, 0, '0);
    cycle();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 12, the word address width of the shared RAM port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the RAM data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, the maximum consecutive display grants while the CPU waits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU access request; held until cpu_gnt.
REQ-007 cpu_wEn  input  1  CPU write (1) or read (0); valid with cpu_req.
REQ-008 cpu_addr  input  ADDRESS_WIDTH  CPU word address.
REQ-009 cpu_dataIn  input  DATA_WIDTH  CPU write data.
REQ-010 cpu_gnt  output  1  CPU access performed this cycle.
REQ-011 cpu_rvalid  output  1  CPU read data valid on cpu_dataOut.
REQ-012 cpu_dataOut  output  DATA_WIDTH  read data to CPU.
REQ-013 disp_req  input  1  display-fetch read request; held until disp_gnt.
REQ-014 disp_addr  input  ADDRESS_WIDTH  display word address.
REQ-015 disp_gnt  output  1  display read performed this cycle.
REQ-016 disp_rvalid  output  1  display read data valid on disp_dataOut.
REQ-017 disp_dataOut  output  DATA_WIDTH  read data to display fetch.
REQ-018 mem_wEn, mem_addr, mem_dataIn  output  1/ADDRESS_WIDTH/DATA_WIDTH  shared RAM port controls.
REQ-019 mem_dataOut  input  DATA_WIDTH  RAM read data, one cycle after address.

Function
REQ-020 At most one of cpu_gnt, disp_gnt SHALL be high in any cycle; grants are combinational from requests and registered state.
REQ-021 In a cpu_gnt cycle mem_addr=cpu_addr, mem_dataIn=cpu_dataIn, mem_wEn=cpu_wEn.
REQ-022 In a disp_gnt cycle mem_addr=disp_addr, mem_wEn=0; display never writes.
REQ-023 With no grant mem_wEn SHALL be 0, mem_addr and mem_dataIn 0.
REQ-024 Only cpu_req: cpu_gnt=1 same cycle; only disp_req: disp_gnt=1 same cycle.
REQ-025 Both requesting: display SHALL win unless burst_cnt==BURST_MAX, in which case the CPU wins.
REQ-026 burst_cnt SHALL increment on each disp_gnt while cpu_req is high, saturate at BURST_MAX, and clear to 0 on cpu_gnt or any cycle cpu_req is low.
REQ-027 Worst-case CPU wait SHALL be BURST_MAX cycles from cpu_req rise to cpu_gnt.
REQ-028 A granted read SHALL produce the owner's rvalid=1 for exactly one cycle, the cycle after the grant; CPU writes produce no rvalid.
REQ-029 Read-owner tag SHALL be registered (states NONE, CPU, DISP) to route rvalid; cpu_dataOut and disp_dataOut SHALL both equal mem_dataOut.
REQ-030 Back-to-back grants SHALL be allowed every cycle; a requester may present a new request the cycle after its grant.
REQ-031 A requester dropping req before grant SHALL simply not be granted; no error state.

Reset
REQ-032 While reset is high: cpu_gnt=0, disp_gnt=0, mem_wEn=0, mem_addr=0, mem_dataIn=0.
REQ-033 The cycle after reset is sampled high: cpu_rvalid=0, disp_rvalid=0, burst_cnt=0, read-owner tag NONE; a read granted the cycle before reset SHALL NOT produce rvalid.

Verification
REQ-034 Only cpu_req=1, cpu_wEn=1, addr=12'd1002, data=32'h5 -> cpu_gnt=1 same cycle, mem_wEn=1, mem_addr=1002, no rvalid.
REQ-035 Only disp_req, disp_addr=12'd10, RAM[10]=32'hA5A5 -> disp_gnt same cycle, disp_rvalid=1 and disp_dataOut=32'hA5A5 next cycle, cpu_rvalid=0.
REQ-036 Both req held continuously, BURST_MAX=4 -> grant pattern D,D,D,D,C repeating; cpu_gnt exactly every 5th cycle.
REQ-037 Both req, CPU drops cpu_req after 2 display grants then reasserts -> burst_cnt restarts at 0; CPU granted after 4 more display grants.
REQ-038 Display read granted at cycle N, reset high at N+1 -> disp_rvalid=0 at N+1 and N+2, all grants 0 during reset.
REQ-039 Random req/addr traffic 10k cycles vs reference model -> never two grants, every read returns matching RAM data with one-cycle latency.
